act_stream_feeder: RTL and testbench
====================================

Name: act_stream_feeder

Overview:
- Transmit side of the accelerator's activation interface.
- Buffers one N×N 16-bit feature map written by the host, then streams it in row-major order on `activation`, qualified by `ce`, into the convolver input of the accelerator.
- Supports downstream stall and reports frame completion.
- Sits between the host/DMA write path and the accelerator top.

Parameters:
- N, 10, feature-map side length; frame holds N*N pixels (range 2..64).
- DW, 16, pixel width in bits; must match the accelerator activation width.
- AW, clog2(N*N+1), pointer/counter width (7 for N=10).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- global_rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe; one pixel per cycle.
- wr_data  in  DW  host pixel; written to the next sequential buffer address.
- start  in  1  request to stream the loaded frame; honoured only in READY.
- stall  in  1  downstream back-pressure; suppresses the next beat.
- activation  out  DW  streamed pixel (registered).
- ce  out  1  beat valid for `activation`; drives the accelerator `ce`.
- busy  out  1  high in LOAD or STREAM.
- load_full  out  1  high in READY, meaning the buffer holds a complete frame.
- done  out  1  one-cycle pulse after the last beat.
- wr_ovf  out  1  sticky flag: a write was attempted while not accepting; cleared by reset or by start.

Behaviour:
- Reset (global_rst=0, asynchronous):
  - state=IDLE; wr_ptr=0, rd_ptr=0.
  - activation=0, ce=0, busy=0, load_full=0, done=0, wr_ovf=0.
  - Buffer contents are don't-care.
  - Reset asserted mid-stream aborts immediately; no done pulse.
- Storage: N*N×DW register array. Write is synchronous. Read is combinational into the output register.
- State machine:
  - IDLE: wr_en=1 writes wr_data to mem[0], sets wr_ptr=1, goes to LOAD (N*N=1 not supported). start is ignored.
  - LOAD: each wr_en=1 writes mem[wr_ptr] and increments wr_ptr. The write that makes wr_ptr=N*N moves to READY. Cycles with wr_en=0 hold state.
  - READY:
    - load_full=1.
    - wr_en=1 is discarded and sets wr_ovf.
    - start=1 clears rd_ptr and wr_ovf and moves to STREAM.
    - If wr_en and start are both high, start wins, the write is discarded, and wr_ovf is still cleared.
  - STREAM:
    - At each edge with stall=0: activation<=mem[rd_ptr], ce<=1, rd_ptr++.
    - At an edge with stall=1: ce<=0 and activation holds its previous value.
    - On the edge that issues beat N*N-1 (rd_ptr=N*N-1, stall=0), move to DONE.
    - wr_en in STREAM is discarded and sets wr_ovf.
  - DONE (one cycle):
    - ce<=0, done<=1.
    - wr_ptr=0, rd_ptr=0, then go to IDLE.
    - The buffer contents are retained but a new frame must be fully rewritten.
- Latency:
  - start sampled at edge t: first beat (ce=1, pixel 0) is visible in cycle t+1, provided stall=0 at edge t+1.
  - Unstalled frame: N*N consecutive ce=1 cycles, then done=1 in the next cycle.
  - done is high exactly one cycle and never overlaps ce=1.
- Stall: stall at edge e gates only the beat issued at e. No beat is lost or duplicated, and order is strictly mem[0]..mem[N*N-1].
- ce is never high outside STREAM.
- busy=1 exactly in LOAD and STREAM.
- load_full and busy are never both high.
- Counters:
  - wr_ptr and rd_ptr range 0..N*N and never wrap past N*N.
  - Pointer widths are AW bits with no overflow.

Test Plan:
- Basic frame (N=10): reset, write pixels 0x0000..0x0063 on 100 consecutive wr_en cycles → load_full=1 the cycle after the 100th write. Pulse start → 100 consecutive ce=1 beats with activation=0x0000..0x0063 in order, then done=1 for one cycle, then busy=0.
- Stall: during stream, hold stall=1 on beats 5–7 (3 edges) → ce=0 for exactly 3 cycles, activation holds 0x0004, resumes with 0x0005. Total ce=1 count is 100 and done arrives 3 cycles later than the unstalled case.
- Overflow and simultaneous events: in READY, assert wr_en=1 → wr_ovf=1 and data is unchanged. Next cycle assert wr_en=1 and start=1 together → STREAM entered, wr_ovf=0, first beat=0x0000.
- Start ignored: start=1 in IDLE and in mid-LOAD (after 40 writes) → no ce and no state change. Finish the remaining 60 writes → READY reached normally.
- Reset mid-stream: drop global_rst low after beat 50 → ce=0, done=0, activation=0 immediately (asynchronous). After release, start alone produces nothing; a full 100-pixel reload is required before streaming again.
- Back-to-back frames: stream a frame, then immediately reload 100 pixels of 0xFFFF and start again → second frame is all 0xFFFF, with no stale data and no extra beats.

Source files
------------

// File: rtl/act_stream_feeder.sv
// act_stream_feeder: buffers one N x N feature map written by the host and
// streams it row-major on `activation`/`ce` into the accelerator, honouring
// downstream stall and pulsing `done` once the whole frame has been sent.
module act_stream_feeder #(
    parameter int N  = 10,
    parameter int DW = 16,
    parameter int AW = $clog2(N * N + 1)
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          stall,
    output logic [DW-1:0] activation,
    output logic          ce,
    output logic          busy,
    output logic          load_full,
    output logic          done,
    output logic          wr_ovf
);

    localparam int unsigned DEPTH = N * N;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_STREAM,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]  act_q, act_d;
    logic           ce_q, ce_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;

    logic [DW-1:0]  mem_q [DEPTH];
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;

    // Frame buffer: plain synchronous write, no reset (contents are don't-care).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= wr_data;
        end
    end

    // Next-state and registered-output logic for the load/stream sequencer.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        act_d     = act_q;
        ce_d      = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;

        case (state_q)
            S_IDLE: begin
                // First pixel of a new frame always lands at address 0.
                if (wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_ptr_d  = AW'(1);
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wr_en) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == LAST) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                // start takes priority; a simultaneous write is dropped silently.
                if (start) begin
                    rd_ptr_d = '0;
                    ovf_d    = 1'b0;
                    state_d  = S_STREAM;
                end else if (wr_en) begin
                    ovf_d = 1'b1;
                end
            end
            S_STREAM: begin
                if (wr_en) begin
                    ovf_d = 1'b1;
                end
                // A stalled edge issues nothing and leaves activation untouched.
                if (!stall) begin
                    act_d    = mem_q[rd_ptr_q];
                    ce_d     = 1'b1;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (rd_ptr_q == LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any stream without a done pulse.
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            act_q    <= '0;
            ce_q     <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            act_q    <= act_d;
            ce_q     <= ce_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign activation = act_q;
    assign ce         = ce_q;
    assign done       = done_q;
    assign wr_ovf     = ovf_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign load_full  = (state_q == S_READY);

endmodule

// File: tb/tb_act_stream_feeder.sv
// Testbench for act_stream_feeder: stimulus pushes the expected beat sequence
// into a queue whenever a frame is started; a negedge monitor pops and compares.
module tb_act_stream_feeder;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int NP = N * N;

    logic          clk = 1'b0;
    logic          global_rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [DW-1:0] activation;
    logic          ce;
    logic          busy;
    logic          load_full;
    logic          done;
    logic          wr_ovf;

    act_stream_feeder #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .start      (start),
        .stall      (stall),
        .activation (activation),
        .ce         (ce),
        .busy       (busy),
        .load_full  (load_full),
        .done       (done),
        .wr_ovf     (wr_ovf)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the frame the host has written, whether it is complete,
    // and the beats/done pulses the DUT still owes us.
    logic [DW-1:0] model_mem [NP];
    bit            model_loaded = 1'b0;
    logic [DW-1:0] exp_q [$];
    int            exp_done = 0;
    int            done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every ce beat must be the next expected pixel; done must follow
    // the last beat and never coincide with ce.
    always @(negedge clk) begin
        logic [DW-1:0] exp_px;
        if (global_rst) begin
            if (ce) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    exp_px = exp_q.pop_front();
                    check("beat_data", 32'(activation), 32'(exp_px));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_without_ce", 32'(ce), 32'd0);
                check("done_after_last_beat", 32'(exp_q.size()), 32'd0);
            end
            if (busy && load_full) begin
                check("busy_and_full", 32'd1, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: pixel=index, 1: all ones, 2: random. gaps inserts idle wr_en cycles.
    task automatic write_range(input int lo, input int hi, input int mode, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            if (gaps) begin
                for (int k = 0; k < 3 && $urandom_range(0, 3) == 0; k++) begin
                    wr_en = 1'b0;
                    tick();
                end
            end
            case (mode)
                0:       wr_data = DW'(i);
                1:       wr_data = '1;
                default: wr_data = DW'($urandom);
            endcase
            model_mem[i] = wr_data;
            wr_en = 1'b1;
            tick();
            if (i == NP - 2) begin
                check("not_full_before_last", 32'(load_full), 32'd0);
                check("busy_while_loading", 32'(busy), 32'd1);
            end
        end
        wr_en = 1'b0;
        if (hi == NP) begin
            model_loaded = 1'b1;
            check("load_full_after_last", 32'(load_full), 32'd1);
            check("not_busy_when_ready", 32'(busy), 32'd0);
        end
        $display("load pixels %0d..%0d mode=%0d gaps=%0d", lo, hi - 1, mode, gaps);
    endtask

    task automatic do_start(input bit with_wr);
        start   = 1'b1;
        wr_en   = with_wr;
        wr_data = 16'hBEEF;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        if (model_loaded) begin
            for (int i = 0; i < NP; i++) exp_q.push_back(model_mem[i]);
            model_loaded = 1'b0;
            exp_done++;
            check("start_clears_ovf", 32'(wr_ovf), 32'd0);
            check("busy_streaming", 32'(busy), 32'd1);
        end
        $display("start pulse with_wr=%0d", with_wr);
    endtask

    // stall_mode 0: none, 1: three stalls before beat 5, 2: random.
    // abort_at > 0 returns as soon as that many beats have been issued.
    task automatic stream(input int stall_mode, input int abort_at);
        int issued = 0;
        int stalls = 0;
        int cyc    = 0;
        while (issued < NP && cyc < 2000) begin
            if (stall_mode == 1)      stall = (issued == 5 && stalls < 3);
            else if (stall_mode == 2) stall = ($urandom_range(0, 3) == 0);
            else                      stall = 1'b0;
            tick();
            cyc++;
            if (stall) begin
                stalls++;
                check("stall_gates_ce", 32'(ce), 32'd0);
                if (issued > 0) check("stall_holds_data", 32'(activation), 32'(model_mem[issued-1]));
            end else begin
                issued++;
            end
            if (abort_at > 0 && issued == abort_at) break;
        end
        stall = 1'b0;
        if (abort_at > 0) begin
            $display("stream aborted after %0d beats", issued);
            return;
        end
        check("stream_finished", 32'(issued), 32'(NP));
        if (stall_mode == 1) check("stall_count", 32'(stalls), 32'd3);
        tick();
        check("done_pulse", 32'(done), 32'd1);
        check("done_ce_low", 32'(ce), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
        check("idle_not_full", 32'(load_full), 32'd0);
        $display("frame streamed, %0d stall cycles", stalls);
    endtask

    initial begin
        // Reset state
        global_rst = 1'b0;
        repeat (3) tick();
        check("rst_activation", 32'(activation), 32'd0);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load_full", 32'(load_full), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_ovf", 32'(wr_ovf), 32'd0);
        global_rst = 1'b1;
        tick();

        // start ignored in IDLE and mid-LOAD
        do_start(1'b0);
        repeat (2) tick();
        check("idle_start_busy", 32'(busy), 32'd0);
        check("idle_start_full", 32'(load_full), 32'd0);
        write_range(0, 40, 0, 1'b0);
        do_start(1'b0);
        tick();
        check("load_start_busy", 32'(busy), 32'd1);
        check("load_start_full", 32'(load_full), 32'd0);
        write_range(40, NP, 0, 1'b0);
        check("no_ovf_after_load", 32'(wr_ovf), 32'd0);

        // Stall on beats 5..7
        do_start(1'b0);
        stream(1, 0);

        // Basic consecutive frame, then overflow and simultaneous wr_en/start
        write_range(0, NP, 0, 1'b0);
        wr_en   = 1'b1;
        wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        check("ovf_set_in_ready", 32'(wr_ovf), 32'd1);
        check("still_ready", 32'(load_full), 32'd1);
        do_start(1'b1);
        stream(0, 0);

        // Back-to-back all-ones frame
        write_range(0, NP, 1, 1'b0);
        do_start(1'b0);
        stream(0, 0);

        // Reset mid-stream after beat 50
        write_range(0, NP, 2, 1'b1);
        do_start(1'b0);
        stream(2, 51);
        @(negedge clk);
        #1;
        global_rst = 1'b0;
        #1;
        check("abort_ce", 32'(ce), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_activation", 32'(activation), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        exp_done--;
        model_loaded = 1'b0;
        repeat (2) tick();
        global_rst = 1'b1;
        tick();
        do_start(1'b0);
        repeat (3) tick();
        check("post_reset_start_busy", 32'(busy), 32'd0);
        check("post_reset_start_full", 32'(load_full), 32'd0);
        write_range(0, NP, 2, 1'b1);
        do_start(1'b0);
        stream(2, 0);

        // Random frames with random gaps and stalls
        repeat (2) begin
            write_range(0, NP, 2, 1'b1);
            do_start(1'b0);
            stream(2, 0);
        end

        repeat (3) tick();
        check("beats_outstanding", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
